// File: rtl/timer_sequencer_if.sv
// Control/table bus between a software or FSM master and the timer sequencer.
interface timer_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW:0]      seq_len;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic             timer_done;
    logic [WIDTH-1:0] load_value;
    logic             reload;
    logic             busy;
    logic [AW-1:0]    seg_idx;
    logic             wrap;
    logic             seq_done;

    modport master (
        output wr_en, wr_addr, wr_data, seq_len, loop_en, start, stop, timer_done,
        input  load_value, reload, busy, seg_idx, wrap, seq_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, seq_len, loop_en, start, stop, timer_done,
        output load_value, reload, busy, seg_idx, wrap, seq_done
    );
endinterface

// File: rtl/timer_sequencer.sv
// Steps an auto-reload timer through a table of periods: one reload per segment,
// advancing on each timer_done, with one-shot, looping and abort behaviour.
module timer_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    timer_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] tbl [DEPTH];

    // Period table; writable in every state, read only when entering LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (bus.wr_en) begin
            tbl[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            load_q   <= '0;
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            load_q   <= load_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

    // Next state; all outputs are registered from the values computed here.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        load_d   = load_q;
        reload_d = 1'b0;
        wrap_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop && (bus.seq_len != '0) &&
                    (bus.seq_len <= LW'(DEPTH))) begin
                    len_d   = bus.seq_len;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = bus.stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // stop takes priority over a coincident timer_done
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.timer_done) begin
                    if ((LW'(idx_q) + LW'(1)) < len_q) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end else if (bus.loop_en) begin
                        idx_d   = '0;
                        wrap_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Present the period in the same cycle as its reload strobe.
        if (state_d == S_LOAD) begin
            reload_d = 1'b1;
            load_d   = tbl[idx_d];
        end
        busy_d = (state_d != S_IDLE);
    end

    assign bus.load_value = load_q;
    assign bus.reload     = reload_q;
    assign bus.busy       = busy_q;
    assign bus.seg_idx    = idx_q;
    assign bus.wrap       = wrap_q;
    assign bus.seq_done   = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: one-shot, loop, abort, ignored inputs,
// live table writes and asynchronous reset.
module tb_timer_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    timer_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    timer_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic [7:0] lv, input logic [1:0] idx);
        chk({tag, "_reload"}, 32'(bus.reload), 32'd1);
        chk({tag, "_load_value"}, 32'(bus.load_value), 32'(lv));
        chk({tag, "_seg_idx"}, 32'(bus.seg_idx), 32'(idx));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_reload"}, 32'(bus.reload), 32'd0);
    endtask

    // Called right after a reload cycle; timer_done is sampled 4 edges later.
    task automatic done_after_reload(input string tag);
        step();
        chk({tag, "_reload_single"}, 32'(bus.reload), 32'd0);
        step();
        step();
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
    endtask

    task automatic write_entry(input logic [1:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] len);
        bus.seq_len = len;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.seq_len      = '0;
        bus.loop_en      = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.timer_done   = 1'b0;

        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_reload", 32'(bus.reload), 32'd0);
        chk("rst_load_value", 32'(bus.load_value), 32'd0);
        chk("rst_seg_idx", 32'(bus.seg_idx), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        chk("rst_seq_done", 32'(bus.seq_done), 32'd0);

        write_entry(2'd0, 8'd3);
        write_entry(2'd1, 8'd5);
        write_entry(2'd2, 8'd7);
        write_entry(2'd3, 8'd2);

        // Ignored inputs in IDLE
        do_start(3'd0);
        chk_idle("len0_start");
        do_start(3'd5);
        chk_idle("len5_start");
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.seq_len = 3'd2;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk_idle("start_stop");
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
        chk_idle("stray_done");
        chk("stray_done_seq_done", 32'(bus.seq_done), 32'd0);

        // One-shot, 3 segments
        do_start(3'd3);
        chk_issue("os0", 8'd3, 2'd0);
        done_after_reload("os0");
        chk_issue("os1", 8'd5, 2'd1);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_start_seg_idx", 32'(bus.seg_idx), 32'd1);
        chk("busy_start_reload", 32'(bus.reload), 32'd0);
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
        chk_issue("os2", 8'd7, 2'd2);
        done_after_reload("os2");
        chk("os_seq_done", 32'(bus.seq_done), 32'd1);
        chk("os_wrap", 32'(bus.wrap), 32'd0);
        chk_idle("os_end");
        chk("os_end_seg_idx", 32'(bus.seg_idx), 32'd2);
        step();
        chk("os_seq_done_pulse", 32'(bus.seq_done), 32'd0);

        // Live table write during WAIT of segment 0
        do_start(3'd3);
        chk_issue("lw0", 8'd3, 2'd0);
        step();
        write_entry(2'd1, 8'd9);
        bus.timer_done = 1'b1;
        step();
        bus.timer_done = 1'b0;
        chk_issue("lw1", 8'd9, 2'd1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk_idle("lw_stop");
        chk("lw_stop_load_value", 32'(bus.load_value), 32'd9);
        write_entry(2'd1, 8'd5);

        // Looping, 2 segments
        bus.loop_en = 1'b1;
        do_start(3'd2);
        chk_issue("lp0", 8'd3, 2'd0);
        done_after_reload("lp0");
        chk_issue("lp1", 8'd5, 2'd1);
        done_after_reload("lp1");
        chk("lp_wrap", 32'(bus.wrap), 32'd1);
        chk("lp_wrap_seq_done", 32'(bus.seq_done), 32'd0);
        chk_issue("lp2", 8'd3, 2'd0);
        done_after_reload("lp2");
        chk("lp_wrap_pulse", 32'(bus.wrap), 32'd0);
        chk_issue("lp3", 8'd5, 2'd1);
        bus.loop_en = 1'b0;
        done_after_reload("lp3");
        chk("lp_seq_done", 32'(bus.seq_done), 32'd1);
        chk("lp_end_wrap", 32'(bus.wrap), 32'd0);
        chk_idle("lp_end");

        // Abort: stop coincident with timer_done in segment 1
        do_start(3'd3);
        chk_issue("ab0", 8'd3, 2'd0);
        done_after_reload("ab0");
        chk_issue("ab1", 8'd5, 2'd1);
        step();
        step();
        step();
        bus.timer_done = 1'b1;
        bus.stop       = 1'b1;
        step();
        bus.timer_done = 1'b0;
        bus.stop       = 1'b0;
        chk_idle("ab_stop");
        chk("ab_seq_done", 32'(bus.seq_done), 32'd0);
        chk("ab_load_value", 32'(bus.load_value), 32'd5);
        chk("ab_seg_idx", 32'(bus.seg_idx), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_after_reload", 32'(bus.reload), 32'd0);
            chk("ab_after_seq_done", 32'(bus.seq_done), 32'd0);
        end

        // Asynchronous reset in the middle of WAIT
        do_start(3'd2);
        chk_issue("rw0", 8'd3, 2'd0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_load_value", 32'(bus.load_value), 32'd0);
        chk("rw_seg_idx", 32'(bus.seg_idx), 32'd0);
        chk("rw_reload", 32'(bus.reload), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("rw_after");
        end
        // Table was cleared by reset
        do_start(3'd1);
        chk_issue("rw_cleared", 8'd0, 2'd0);
        done_after_reload("rw_cleared");
        chk("rw_seq_done", 32'(bus.seq_done), 32'd1);
        chk_idle("rw_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
